// File: rtl/cam_engine.sv
// Sequential associative-processor CAM: direct read/write, masked match with tag
// accumulation, and tag-guided masked write, swept LANES rows per cycle.
module cam_engine #(
  parameter  int unsigned WORD_SIZE = 8,
  parameter  int unsigned ROWS      = 512,
  parameter  int unsigned LANES     = 64,
  localparam int unsigned AB        = $clog2(ROWS)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [AB-1:0]        cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_key,
  input  logic [WORD_SIZE-1:0] cmd_mask,
  input  logic [WORD_SIZE-1:0] cmd_data,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic [ROWS-1:0]      tags,
  output logic                 match_any,
  output logic [AB-1:0]        match_first,
  output logic [AB:0]          match_count
);

  localparam int unsigned S  = ROWS / LANES;
  localparam int unsigned SB = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned LB = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, MATCH, TWRITE} state_t;
  typedef enum logic [2:0] {
    OP_WRITE       = 3'b000,
    OP_READ        = 3'b001,
    OP_MATCH_SET   = 3'b010,
    OP_MATCH_AND   = 3'b011,
    OP_MATCH_OR    = 3'b100,
    OP_TAG_WRITE   = 3'b101,
    OP_TAG_CLEAR   = 3'b110,
    OP_TAG_SET_ALL = 3'b111
  } op_t;

  state_t               state;
  logic [SB-1:0]        seg;
  op_t                  op_q;
  logic [WORD_SIZE-1:0] key_q, mask_q, data_q;
  logic [WORD_SIZE-1:0] mem [ROWS];

  // Shadow summaries built across a sweep and committed on the last segment
  logic [AB:0]          sh_count;
  logic [AB-1:0]        sh_first;
  logic                 sh_found;

  logic [AB-1:0]        lane_row [LANES];
  logic [LANES-1:0]     seg_tag;
  logic [LB:0]          seg_pop;
  logic                 seg_any;
  logic [AB-1:0]        seg_first_row;
  logic                 hit;
  logic [AB:0]          next_count;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    lane_row      = '{default: '0};
    seg_tag       = '0;
    seg_pop       = '0;
    seg_any       = 1'b0;
    seg_first_row = '0;
    hit           = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_row[l] = AB'(32'(seg) * LANES + l);
      hit = (((mem[lane_row[l]] ^ key_q) & mask_q) == '0);
      case (op_q)
        OP_MATCH_AND: seg_tag[l] = tags[lane_row[l]] & hit;
        OP_MATCH_OR:  seg_tag[l] = tags[lane_row[l]] | hit;
        default:      seg_tag[l] = hit;
      endcase
      seg_pop = seg_pop + (LB+1)'(seg_tag[l]);
      if (seg_tag[l] && !seg_any) begin
        seg_any       = 1'b1;
        seg_first_row = lane_row[l];
      end
    end
    next_count = sh_count + (AB+1)'(seg_pop);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state       <= IDLE;
      seg         <= '0;
      op_q        <= OP_WRITE;
      key_q       <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      for (int unsigned r = 0; r < ROWS; r++) mem[r] <= '0;
      tags        <= '0;
      match_any   <= 1'b0;
      match_first <= '0;
      match_count <= '0;
      sh_count    <= '0;
      sh_first    <= '0;
      sh_found    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q     <= op_t'(cmd_op);
            key_q    <= cmd_key;
            mask_q   <= cmd_mask;
            data_q   <= cmd_data;
            seg      <= '0;
            sh_count <= '0;
            sh_first <= '0;
            sh_found <= 1'b0;
            case (op_t'(cmd_op))
              OP_WRITE: mem[cmd_addr] <= cmd_data;
              OP_READ: begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem[cmd_addr];
              end
              OP_MATCH_SET, OP_MATCH_AND, OP_MATCH_OR: state <= MATCH;
              OP_TAG_WRITE: state <= TWRITE;
              OP_TAG_CLEAR: begin
                tags        <= '0;
                match_any   <= 1'b0;
                match_first <= '0;
                match_count <= '0;
              end
              default: begin
                tags        <= '1;
                match_any   <= 1'b1;
                match_first <= '0;
                match_count <= (AB+1)'(ROWS);
              end
            endcase
          end
        end
        MATCH: begin
          for (int unsigned l = 0; l < LANES; l++) tags[lane_row[l]] <= seg_tag[l];
          sh_count <= next_count;
          if (!sh_found && seg_any) begin
            sh_found <= 1'b1;
            sh_first <= seg_first_row;
          end
          if (seg == SB'(S-1)) begin
            state       <= IDLE;
            match_count <= next_count;
            match_any   <= (next_count != '0);
            match_first <= sh_found ? sh_first : seg_first_row;
          end else begin
            seg <= seg + 1'b1;
          end
        end
        TWRITE: begin
          for (int unsigned l = 0; l < LANES; l++)
            if (tags[lane_row[l]])
              mem[lane_row[l]] <= (mem[lane_row[l]] & ~mask_q) | (data_q & mask_q);
          if (seg == SB'(S-1)) state <= IDLE;
          else                 seg   <= seg + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_engine.sv
// Directed bench for cam_engine with 16 rows, 4 lanes (4-cycle sweeps).
module tb_cam_engine;

  localparam int unsigned W = 8;
  localparam int unsigned R = 16;
  localparam int unsigned L = 4;

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [3:0]   cmd_addr = '0;
  logic [W-1:0] cmd_key = '0, cmd_mask = '0, cmd_data = '0;
  logic         busy, rsp_valid;
  logic [W-1:0] rsp_data;
  logic [R-1:0] tags;
  logic         match_any;
  logic [3:0]   match_first;
  logic [4:0]   match_count;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] model [R];

  cam_engine #(.WORD_SIZE(W), .ROWS(R), .LANES(L)) dut (
    .clock(clock), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_key(cmd_key), .cmd_mask(cmd_mask),
    .cmd_data(cmd_data), .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tags(tags), .match_any(match_any), .match_first(match_first),
    .match_count(match_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sum(input string tag, input logic [15:0] t, input logic a,
                         input logic [3:0] f, input logic [4:0] c);
    chk({tag, ".tags"}, 32'(tags), 32'(t));
    chk({tag, ".any"}, 32'(match_any), 32'(a));
    chk({tag, ".first"}, 32'(match_first), 32'(f));
    chk({tag, ".count"}, 32'(match_count), 32'(c));
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] key,
                       input logic [7:0] mask, input logic [7:0] data);
    cmd_op = op; cmd_addr = addr; cmd_key = key; cmd_mask = mask; cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    issue(3'b000, 4'(a), 8'h00, 8'h00, d);
    model[a] = d;
  endtask

  task automatic rd(input string tag, input int a, input logic [7:0] exp);
    issue(3'b001, 4'(a), 8'h00, 8'h00, 8'h00);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp));
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < R; i++) rd(tag, i, model[i]);
  endtask

  task automatic sweep(input string tag, input logic [2:0] op, input logic [7:0] key,
                       input logic [7:0] mask, input logic [7:0] data);
    int n;
    logic [4:0] held;
    held = match_count;
    issue(op, 4'h0, key, mask, data);
    n = 0;
    while (busy && n < 20) begin
      chk({tag, ".ready_low"}, 32'(cmd_ready), 32'd0);
      chk({tag, ".count_held"}, 32'(match_count), 32'(held));
      @(posedge clock); #1;
      n++;
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'd4);
  endtask

  initial begin
    int n;
    logic early;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_sum("reset", 16'h0000, 1'b0, 4'd0, 5'd0);
    chk("reset.ready", 32'(cmd_ready), 32'd1);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < R; i++) model[i] = 8'h00;
    rd_all("reset_read");

    // Write / single match
    for (int i = 0; i < R; i++) wr(i, 8'(i * 17));
    wr(5, 8'h5A);
    rd("wr_then_rd", 5, 8'h5A);
    wr(5, 8'h55);
    sweep("match33", 3'b010, 8'h33, 8'hFF, 8'h00);
    chk_sum("match33", 16'h0008, 1'b1, 4'd3, 5'd1);

    // Accumulate
    for (int i = 0; i < R; i++) wr(i, 8'(i));
    sweep("set_odd", 3'b010, 8'h01, 8'h01, 8'h00);
    chk_sum("set_odd", 16'hAAAA, 1'b1, 4'd1, 5'd8);
    sweep("and_b3", 3'b011, 8'h08, 8'h08, 8'h00);
    chk_sum("and_b3", 16'hAA00, 1'b1, 4'd9, 5'd4);
    sweep("or_zero", 3'b100, 8'h00, 8'h0F, 8'h00);
    chk_sum("or_zero", 16'hAA01, 1'b1, 4'd0, 5'd5);

    // Tagged write
    sweep("set_odd2", 3'b010, 8'h01, 8'h01, 8'h00);
    sweep("and_b3_2", 3'b011, 8'h08, 8'h08, 8'h00);
    sweep("twrite", 3'b101, 8'h00, 8'hF0, 8'hF0);
    chk_sum("twrite", 16'hAA00, 1'b1, 4'd9, 5'd4);
    for (int i = 9; i < R; i += 2) model[i] = 8'hF0 | 8'(i);
    rd_all("twrite_read");

    // Set-all / clear
    issue(3'b111, 4'h0, 8'h00, 8'h00, 8'h00);
    chk_sum("set_all", 16'hFFFF, 1'b1, 4'd0, 5'd16);
    issue(3'b110, 4'h0, 8'h00, 8'h00, 8'h00);
    chk_sum("clear", 16'h0000, 1'b0, 4'd0, 5'd0);

    // Tagged write with no tags set changes nothing
    sweep("twrite_none", 3'b101, 8'h00, 8'hFF, 8'h00);
    rd_all("twrite_none_read");

    // Held READ during a mask-0 sweep
    cmd_op = 3'b010; cmd_key = 8'hA5; cmd_mask = 8'h00; cmd_valid = 1'b1;
    @(posedge clock); #1;
    chk("hold.busy", 32'(busy), 32'd1);
    cmd_op = 3'b001; cmd_addr = 4'd9;
    n = 0; early = 1'b0;
    while (busy && n < 20) begin
      if (rsp_valid) early = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    chk("hold.busy_cycles", 32'(n), 32'd4);
    chk("hold.no_early_accept", 32'(early), 32'd0);
    chk("hold.rsp_idle", 32'(rsp_valid), 32'd0);
    chk_sum("mask0", 16'hFFFF, 1'b1, 4'd0, 5'd16);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("hold.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("hold.rsp_data", 32'(rsp_data), 32'hF9);
    @(posedge clock); #1;
    chk("hold.pulse_end", 32'(rsp_valid), 32'd0);
    chk("hold.data_held", 32'(rsp_data), 32'hF9);

    // Reset in the second busy cycle of a sweep
    issue(3'b111, 4'h0, 8'h00, 8'h00, 8'h00);
    issue(3'b010, 4'h0, 8'h33, 8'hFF, 8'h00);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ready", 32'(cmd_ready), 32'd1);
    chk("midrst.rsp_data", 32'(rsp_data), 32'd0);
    chk_sum("midrst", 16'h0000, 1'b0, 4'd0, 5'd0);
    rst = 1'b1;
    for (int i = 0; i < R; i++) model[i] = 8'h00;
    rd_all("midrst_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
